// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-bit MULT/MULTU/DIV/DIVU engine with the
// architectural HI/LO registers. Operands come straight from the register
// file read ports (rs on SrcA, rt on SrcB). One result bit is produced per
// cycle. The control path stalls on Busy.
//
// Handshake: Start is a request that is sampled only on an edge where
// Busy=0 (state IDLE). The operands and Op are captured at that edge (t0).
// Busy stays high for the 33 following cycles. HI/LO update at edge t33,
// and Done pulses high for the single cycle after t33. There is no queueing:
// Start while Busy=1 is dropped, and so are MoveHi/MoveLo while Busy=1.
module mult_div_unit #(
   parameter int dataWidth = 32
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 Start,
   input  logic [1:0]           Op,
   input  logic [dataWidth-1:0] SrcA,
   input  logic [dataWidth-1:0] SrcB,
   input  logic                 MoveHi,
   input  logic                 MoveLo,
   output logic                 Busy,
   output logic                 Done,
   output logic [dataWidth-1:0] HI,
   output logic [dataWidth-1:0] LO,
   output logic [1:0]           dbg_state_o
);

   localparam int W  = dataWidth;
   localparam int CW = $clog2(dataWidth);
   localparam logic [CW-1:0] CntLast = CW'(dataWidth - 1);

   // Op encoding: bit 1 selects divide, bit 0 selects unsigned.
   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_e;

   state_e state_q, state_d;

   // FSM control strobes (decoded from the state register)
   logic load_en;
   logic calc_en;
   logic fix_en;
   logic busy;

   // Captured operation
   logic [1:0]    op_q, op_d;
   logic [W-1:0]  a_q, a_d;      // multiplicand / dividend magnitude
   logic [W-1:0]  b_q, b_d;      // multiplier / divisor magnitude
   logic          neg_a_q, neg_a_d;
   logic          neg_b_q, neg_b_d;
   logic          div0_q, div0_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Iteration state
   logic [2*W-1:0] acc_q, acc_d; // product accumulator
   logic [W:0]     rem_q, rem_d; // partial remainder
   logic [W-1:0]   quo_q, quo_d; // quotient bits, shifted in from the LSB

   // Architectural registers and the completion pulse
   logic [W-1:0] hi_q, hi_d;
   logic [W-1:0] lo_q, lo_d;
   logic         done_q, done_d;

   // Operand preprocessing at accept time
   logic         op_signed;
   logic         in_neg_a;
   logic         in_neg_b;
   logic [W-1:0] in_mag_a;
   logic [W-1:0] in_mag_b;

   // One iteration step
   logic [W:0]     div_shift;
   logic [W:0]     div_ext;
   logic [2*W-1:0] mul_addend;

   // Sign-corrected results written in FIX
   logic           res_neg;
   logic [2*W-1:0] prod_fix;
   logic [W-1:0]   quo_fix;
   logic [W-1:0]   rem_fix;
   logic [W-1:0]   res_hi;
   logic [W-1:0]   res_lo;

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------

   // State register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: accept in IDLE, run the CALC steps, one FIX cycle, back to IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (Start) state_d = S_CALC;
         S_CALC:  if (cnt_q == '0) state_d = S_FIX;
         S_FIX:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode: strobes for the datapath and the registered-state Busy
   always_comb begin
      load_en = 1'b0;
      calc_en = 1'b0;
      fix_en  = 1'b0;
      busy    = 1'b1;
      case (state_q)
         S_IDLE: begin
            busy    = 1'b0;
            load_en = Start;
         end
         S_CALC:  calc_en = 1'b1;
         S_FIX:   fix_en  = 1'b1;
         default: busy    = 1'b0;
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath
   // ------------------------------------------------------------------

   // Split the incoming operands into magnitude and sign for signed ops
   always_comb begin
      op_signed = ~Op[0];
      in_neg_a  = op_signed & SrcA[W-1];
      in_neg_b  = op_signed & SrcB[W-1];
      in_mag_a  = in_neg_a ? -SrcA : SrcA;
      in_mag_b  = in_neg_b ? -SrcB : SrcB;
   end

   // One step of shift-add multiply and restoring divide (MSB first)
   always_comb begin
      mul_addend = b_q[cnt_q] ? {{W{1'b0}}, a_q} : '0;
      div_shift  = {rem_q[W-1:0], a_q[cnt_q]};
      div_ext    = {1'b0, b_q};
   end

   // Next values of the captured operation and the iteration registers
   always_comb begin
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      neg_a_d = neg_a_q;
      neg_b_d = neg_b_q;
      div0_d  = div0_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      if (load_en) begin
         op_d    = Op;
         a_d     = in_mag_a;
         b_d     = in_mag_b;
         neg_a_d = in_neg_a;
         neg_b_d = in_neg_b;
         div0_d  = (SrcB == '0);
         cnt_d   = CntLast;
         acc_d   = '0;
         rem_d   = '0;
         quo_d   = '0;
      end else if (calc_en) begin
         if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
         end
         if (op_q[1]) begin
            // Restoring divide: subtract only when the trial stays non-negative.
            // A zero divisor therefore yields an all-ones quotient and leaves
            // the dividend magnitude as the remainder.
            if (div_shift >= div_ext) begin
               rem_d = div_shift - div_ext;
               quo_d = {quo_q[W-2:0], 1'b1};
            end else begin
               rem_d = div_shift;
               quo_d = {quo_q[W-2:0], 1'b0};
            end
         end else begin
            acc_d = {acc_q[2*W-2:0], 1'b0} + mul_addend;
         end
      end
   end

   // Operation and iteration registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         op_q    <= OP_MULT;
         a_q     <= '0;
         b_q     <= '0;
         neg_a_q <= 1'b0;
         neg_b_q <= 1'b0;
         div0_q  <= 1'b0;
         cnt_q   <= '0;
         acc_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
      end else begin
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         neg_a_q <= neg_a_d;
         neg_b_q <= neg_b_d;
         div0_q  <= div0_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
      end
   end

   // Sign correction of the magnitude result.
   // 0x80000000 / -1 comes out as 0x80000000 rem 0 with no special case.
   // For a zero divisor the remainder path already restores the original
   // SrcA, so only the quotient is forced.
   always_comb begin
      res_neg  = neg_a_q ^ neg_b_q;
      prod_fix = res_neg ? -acc_q : acc_q;
      quo_fix  = res_neg ? -quo_q : quo_q;
      rem_fix  = neg_a_q ? -rem_q[W-1:0] : rem_q[W-1:0];
      if (div0_q) begin
         quo_fix = '1;
      end
      case (op_q)
         OP_DIV, OP_DIVU: begin
            res_hi = rem_fix;
            res_lo = quo_fix;
         end
         default: begin
            res_hi = prod_fix[2*W-1:W];
            res_lo = prod_fix[W-1:0];
         end
      endcase
   end

   // HI/LO: result write in FIX, otherwise mthi/mtlo while idle
   always_comb begin
      hi_d   = hi_q;
      lo_d   = lo_q;
      done_d = fix_en;
      if (fix_en) begin
         hi_d = res_hi;
         lo_d = res_lo;
      end else if (!busy) begin
         if (MoveHi) hi_d = SrcA;
         if (MoveLo) lo_d = SrcA;
      end
   end

   // Architectural registers and the Done pulse
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         hi_q   <= '0;
         lo_q   <= '0;
         done_q <= 1'b0;
      end else begin
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         done_q <= done_d;
      end
   end

   assign Busy        = busy;
   assign Done        = done_q;
   assign HI          = hi_q;
   assign LO          = lo_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: directed cases plus randomized operations
// checked against a plain-arithmetic reference model.
module tb_mult_div_unit;

   logic        CLK;
   logic        RST_N;
   logic        Start;
   logic [1:0]  Op;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic        MoveHi;
   logic        MoveLo;
   logic        Busy;
   logic        Done;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_pass   = 0;

   mult_div_unit #(.dataWidth(32)) dut (
      .CLK         (CLK),
      .RST_N       (RST_N),
      .Start       (Start),
      .Op          (Op),
      .SrcA        (SrcA),
      .SrcB        (SrcB),
      .MoveHi      (MoveHi),
      .MoveLo      (MoveLo),
      .Busy        (Busy),
      .Done        (Done),
      .HI          (HI),
      .LO          (LO),
      .dbg_state_o (dbg_state)
   );

   // Clock
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Single checking task
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model: returns {HI, LO}
   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      longint sa, sb, q, r, p;
      logic [63:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'b00: begin
            p   = sa * sb;
            res = p;
         end
         2'b01: res = {32'd0, a} * {32'd0, b};
         2'b10: begin
            if (b == 32'd0) begin
               res = {a, 32'hFFFF_FFFF};
            end else begin
               q   = sa / sb;
               r   = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
         default: begin
            if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else            res = {a % b, a / b};
         end
      endcase
      return res;
   endfunction

   // Driver: present a request; must be called #1 after an edge with Busy=0.
   // Returns #1 after the accepting edge t0.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic mhi, input logic mlo);
      Start  = 1'b1;
      Op     = op;
      SrcA   = a;
      SrcB   = b;
      MoveHi = mhi;
      MoveLo = mlo;
      @(posedge CLK);
      #1;
      Start  = 1'b0;
      MoveHi = 1'b0;
      MoveLo = 1'b0;
      SrcA   = $urandom();
      SrcB   = $urandom();
      check("busy_after_t0", Busy, 1);
      check("done_after_t0", Done, 0);
   endtask

   // Wait (bounded) for Done and compare latency and result
   task automatic wait_done(input logic [63:0] exp, input int elapsed, input string tag);
      int k;
      int gap;
      k   = elapsed;
      gap = 0;
      while (!Done && k < 40) begin
         @(posedge CLK);
         #1;
         k++;
         if (!Done && !Busy) gap++;
      end
      check({tag, "_latency"}, k, 33);
      check({tag, "_busy_held"}, gap, 0);
      check({tag, "_busy_low_at_done"}, Busy, 0);
      check({tag, "_hilo"}, {HI, LO}, exp);
   endtask

   initial begin
      logic [1:0]  r_op;
      logic [31:0] r_a;
      logic [31:0] r_b;
      int          pick;
      int          dones;

      RST_N  = 1'b0;
      Start  = 1'b0;
      Op     = 2'b00;
      SrcA   = '0;
      SrcB   = '0;
      MoveHi = 1'b0;
      MoveLo = 1'b0;

      // Reset state
      repeat (3) @(posedge CLK);
      #1;
      check("rst_hi", HI, 0);
      check("rst_lo", LO, 0);
      check("rst_busy", Busy, 0);
      check("rst_done", Done, 0);
      RST_N = 1'b1;
      @(posedge CLK);
      #1;

      // MULT 7 * -3
      issue(2'b00, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0);
      wait_done(64'hFFFF_FFFF_FFFF_FFEB, 0, "mult_7_m3");
      @(posedge CLK);
      #1;
      check("done_one_cycle", Done, 0);

      // MULTU all-ones squared
      issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
      wait_done(64'hFFFF_FFFE_0000_0001, 0, "multu_ones");

      // DIV -7 / 2 (issued in the Done cycle: back-to-back)
      issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
      wait_done(64'hFFFF_FFFF_FFFF_FFFD, 0, "div_m7_2");

      // DIV overflow
      issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
      wait_done(64'h0000_0000_8000_0000, 0, "div_ovf");

      // DIVU and DIV by zero
      issue(2'b11, 32'd100, 32'd0, 1'b0, 1'b0);
      wait_done(64'h0000_0064_FFFF_FFFF, 0, "divu_zero");
      issue(2'b10, 32'hFFFF_FF00, 32'd0, 1'b0, 1'b0);
      wait_done(64'hFFFF_FF00_FFFF_FFFF, 0, "div_zero");

      // Start and MoveLo while busy are ignored
      issue(2'b11, 32'd1000, 32'd7, 1'b0, 1'b0);
      repeat (4) @(posedge CLK);
      #1;
      Start  = 1'b1;
      Op     = 2'b00;
      SrcA   = 32'h1234;
      SrcB   = 32'd5;
      MoveLo = 1'b1;
      @(posedge CLK);
      #1;
      Start  = 1'b0;
      MoveLo = 1'b0;
      wait_done(model(2'b11, 32'd1000, 32'd7), 5, "busy_ignore");
      SrcA   = 32'h1234;
      MoveLo = 1'b1;
      @(posedge CLK);
      #1;
      MoveLo = 1'b0;
      check("mtlo_after_done_lo", LO, 32'h1234);
      check("mtlo_after_done_hi", HI, 32'd6);

      // Both moves together while idle
      SrcA   = 32'hCAFE_F00D;
      MoveHi = 1'b1;
      MoveLo = 1'b1;
      @(posedge CLK);
      #1;
      MoveHi = 1'b0;
      MoveLo = 1'b0;
      check("mthi_mtlo_both", {HI, LO}, 64'hCAFE_F00D_CAFE_F00D);

      // Move together with Start: move lands at t0, result overwrites later
      issue(2'b00, 32'hABCD_0000, 32'd3, 1'b1, 1'b0);
      check("move_with_start_hi", HI, 32'hABCD_0000);
      wait_done(model(2'b00, 32'hABCD_0000, 32'd3), 0, "move_with_start");

      // Randomized operations, issued back-to-back from the Done cycle
      for (int i = 0; i < 14; i++) begin
         r_op = 2'($urandom_range(0, 3));
         r_a  = $urandom();
         r_b  = $urandom();
         pick = $urandom_range(0, 7);
         if (pick == 0) r_b = 32'd0;
         if (pick == 1) r_a = 32'h8000_0000;
         if (pick == 2) r_b = 32'($urandom_range(1, 5));
         if (pick == 3) r_b = 32'hFFFF_FFFF;
         if (pick == 4) r_b = 32'h8000_0000;
         issue(r_op, r_a, r_b, 1'b0, 1'b0);
         wait_done(model(r_op, r_a, r_b), 0, "rand");
      end

      // Reset mid-operation aborts it
      issue(2'b01, 32'h1357_9BDF, 32'h2468_ACE0, 1'b0, 1'b0);
      repeat (10) @(posedge CLK);
      #1;
      RST_N = 1'b0;
      #1;
      check("midrst_hi", HI, 0);
      check("midrst_lo", LO, 0);
      check("midrst_busy", Busy, 0);
      check("midrst_done", Done, 0);
      repeat (3) @(posedge CLK);
      #1;
      RST_N = 1'b1;
      dones = 0;
      repeat (40) begin
         @(posedge CLK);
         #1;
         if (Done) dones++;
      end
      check("midrst_no_done", dones, 0);

      // Recovery after reset
      issue(2'b10, 32'd12345, 32'hFFFF_FFF6, 1'b0, 1'b0);
      wait_done(model(2'b10, 32'd12345, 32'hFFFF_FFF6), 0, "after_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
